// File: rtl/rf_multiport.sv
// Multi-port general-purpose register file: NRD combinational read ports, two
// prioritised write ports, optional write-to-read bypass and per-register pending-write counters.
module rf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 3,
    parameter int BYPASS = 1,
    parameter int PEND_W = 2,
    parameter int TRACE  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic [31:0]           wpc0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic [31:0]           wpc1,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_a,
    output logic                  iss_ok,
    output logic                  err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned SW    = PEND_W + 2;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [PEND_W-1:0] cnt     [DEPTH];
    logic [PEND_W-1:0] cnt_nxt [DEPTH];
    logic [1:0]        dec     [DEPTH];
    logic [SW-1:0]     sum;
    logic              err_set;
    logic [ADDR_W-1:0] rda;
    logic [DATA_W-1:0] rdv;

    assign iss_ok = (iss_a == '0) || (cnt[iss_a] != CNT_MAX);

    // Pending counters: sum cannot exceed CNT_MAX because a full counter refuses issues.
    always_comb begin
        err_set = 1'b0;
        sum     = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            dec[r]     = 2'd0;
            cnt_nxt[r] = '0;
            if (r != 0) begin
                dec[r] = 2'(we0 && wa0 == ADDR_W'(r)) + 2'(we1 && wa1 == ADDR_W'(r));
                sum    = SW'(cnt[r]) + SW'(iss_en && iss_a == ADDR_W'(r) && iss_ok);
                if (sum < SW'(dec[r])) begin
                    cnt_nxt[r] = '0;
                    err_set    = 1'b1;
                end else begin
                    cnt_nxt[r] = PEND_W'(sum - SW'(dec[r]));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < DEPTH; r++) begin
                if (we1 && wa1 == ADDR_W'(r)) begin
                    mem[r] <= wd1;
                end else if (we0 && wa0 == ADDR_W'(r)) begin
                    mem[r] <= wd0;
                end
                cnt[r] <= cnt_nxt[r];
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Busy ignores a same-cycle issue so a register retiring this cycle reads as free.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        rda   = '0;
        rdv   = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rda = ra[k*ADDR_W +: ADDR_W];
            rdv = mem[rda];
            if (BYPASS != 0) begin
                if (we1 && wa1 == rda) begin
                    rdv = wd1;
                end else if (we0 && wa0 == rda) begin
                    rdv = wd0;
                end
            end
            if (rda == '0) begin
                rdv = '0;
            end
            if (reset) begin
                rd[k*DATA_W +: DATA_W] = rdv;
                rbusy[k]               = SW'(cnt[rda]) > SW'(dec[rda]);
            end
        end
    end

`ifndef SYNTHESIS
    generate
        if (TRACE != 0) begin : g_trace
            always @(posedge clk) begin
                if (reset) begin
                    if (we0 && !(we1 && wa1 == wa0)) begin
                        $display("@%h: $%d <= %h", wpc0, wa0, wd0);
                    end
                    if (we1) begin
                        $display("@%h: $%d <= %h", wpc1, wa1, wd1);
                    end
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: stimulus pushes expected values into a queue,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_rf_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] ra;
    logic [95:0] rd;
    logic [2:0]  rbusy;
    logic        we0, we1, iss_en;
    logic [4:0]  wa0, wa1, iss_a;
    logic [31:0] wd0, wd1, wpc0, wpc1;
    logic        iss_ok, err;

    typedef struct packed {
        logic [1:0]  kind;   // 0 rd, 1 rbusy, 2 iss_ok, 3 err
        logic [1:0]  idx;
        logic [31:0] val;
    } exp_t;

    exp_t  eq[$];
    string nq[$];
    int    total  = 0;
    int    passed = 0;

    rf_multiport #(
        .DATA_W(32), .ADDR_W(5), .NRD(3), .BYPASS(1), .PEND_W(2), .TRACE(1)
    ) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .wpc0(wpc0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .wpc1(wpc1),
        .iss_en(iss_en), .iss_a(iss_a), .iss_ok(iss_ok), .err(err)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input string nm, input logic [1:0] kind,
                            input logic [1:0] idx, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        eq.push_back(e);
        nq.push_back(nm);
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    endtask

    task automatic set_ra(input int k, input logic [4:0] a);
        ra[k*5 +: 5] = a;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        string       nm;
        logic [31:0] act;
        while (eq.size() > 0) begin
            e  = eq.pop_front();
            nm = nq.pop_front();
            case (e.kind)
                2'd0:    act = rd[e.idx*32 +: 32];
                2'd1:    act = {31'd0, rbusy[e.idx]};
                2'd2:    act = {31'd0, iss_ok};
                default: act = {31'd0, err};
            endcase
            total++;
            if (act === e.val) passed++;
            else $display("FAIL %s: got %h expected %h", nm, act, e.val);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; ra = '0;
        we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
        wa0 = '0; wa1 = '0; iss_a = '0;
        wd0 = '0; wd1 = '0; wpc0 = 32'h100; wpc1 = 32'h104;

        // Write attempted while reset is held
        cyc(); we0 = 1; wa0 = 3; wd0 = 32'hDEAD; set_ra(0, 3);
        expect_v("rst_rd0", 0, 0, 32'h0);
        expect_v("rst_err", 3, 0, 32'h0);
        expect_v("rst_busy", 1, 0, 32'h0);
        cyc(); we0 = 1; wa0 = 3; wd0 = 32'hDEAD;
        expect_v("rst_rd0_b", 0, 0, 32'h0);
        cyc(); reset = 1'b1;
        expect_v("rst_reg3_kept0", 0, 0, 32'h0);
        expect_v("rst_err_rel", 3, 0, 32'h0);
        cyc(); iss_en = 1; iss_a = 3;
        expect_v("iss3_ok", 2, 0, 32'h1);
        cyc(); we0 = 1; wa0 = 3; wd0 = 32'hDEAD; set_ra(1, 3);
        expect_v("byp3_rd0", 0, 0, 32'hDEAD);
        expect_v("byp3_rd1", 0, 1, 32'hDEAD);
        expect_v("wb3_busy", 1, 0, 32'h0);
        cyc();
        expect_v("reg3_rd0", 0, 0, 32'hDEAD);
        expect_v("reg3_err", 3, 0, 32'h0);

        // Dual write collision on r7
        cyc(); iss_en = 1; iss_a = 7;
        cyc(); iss_en = 1; iss_a = 7; set_ra(0, 7);
        expect_v("r7_busy_1", 1, 0, 32'h1);
        cyc(); we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h1111; wd1 = 32'h2222;
        expect_v("coll_byp", 0, 0, 32'h2222);
        expect_v("coll_busy", 1, 0, 32'h0);
        cyc();
        expect_v("coll_reg", 0, 0, 32'h2222);
        expect_v("coll_busy_after", 1, 0, 32'h0);
        expect_v("coll_err", 3, 0, 32'h0);

        // Register zero
        cyc(); we1 = 1; wa1 = 0; wd1 = 32'hFFFF_FFFF; iss_en = 1; iss_a = 0; set_ra(0, 0);
        expect_v("r0_rd", 0, 0, 32'h0);
        expect_v("r0_busy", 1, 0, 32'h0);
        expect_v("r0_iss_ok", 2, 0, 32'h1);
        cyc();
        expect_v("r0_rd_after", 0, 0, 32'h0);
        expect_v("r0_busy_after", 1, 0, 32'h0);
        expect_v("r0_err", 3, 0, 32'h0);

        // Saturation of r5
        cyc(); iss_en = 1; iss_a = 5; set_ra(0, 5);
        expect_v("sat_iss1", 2, 0, 32'h1);
        expect_v("sat_busy0", 1, 0, 32'h0);
        cyc(); iss_en = 1; iss_a = 5;
        expect_v("sat_iss2", 2, 0, 32'h1);
        cyc(); iss_en = 1; iss_a = 5;
        expect_v("sat_iss3", 2, 0, 32'h1);
        cyc(); iss_en = 1; iss_a = 5;
        expect_v("sat_iss4_refused", 2, 0, 32'h0);
        expect_v("sat_busy", 1, 0, 32'h1);
        cyc(); iss_a = 5;
        expect_v("sat_still_full", 2, 0, 32'h0);
        expect_v("sat_no_err", 3, 0, 32'h0);
        cyc(); we0 = 1; wa0 = 5; wd0 = 32'h5A1;
        expect_v("sat_wb1_byp", 0, 0, 32'h5A1);
        expect_v("sat_wb1_busy", 1, 0, 32'h1);
        cyc(); we0 = 1; wa0 = 5; wd0 = 32'h5A2;
        expect_v("sat_wb2_busy", 1, 0, 32'h1);
        cyc(); we1 = 1; wa1 = 5; wd1 = 32'h5A3;
        expect_v("sat_wb3_busy", 1, 0, 32'h0);
        cyc();
        expect_v("sat_rd", 0, 0, 32'h5A3);
        expect_v("sat_idle_busy", 1, 0, 32'h0);
        expect_v("sat_err", 3, 0, 32'h0);

        // Issue and write-back to r9 in the same cycle
        cyc(); iss_en = 1; iss_a = 9; set_ra(0, 9);
        cyc(); iss_en = 1; iss_a = 9; we0 = 1; wa0 = 9; wd0 = 32'h99;
        expect_v("iw_busy", 1, 0, 32'h0);
        expect_v("iw_ok", 2, 0, 32'h1);
        cyc(); set_ra(1, 3); set_ra(2, 7);
        expect_v("iw_busy_next", 1, 0, 32'h1);
        expect_v("iw_rd", 0, 0, 32'h99);
        expect_v("mp_rd1", 0, 1, 32'hDEAD);
        expect_v("mp_rd2", 0, 2, 32'h2222);
        expect_v("iw_err", 3, 0, 32'h0);

        // Underflow on r12 and sticky error
        cyc(); we1 = 1; wa1 = 12; wd1 = 32'hCC; set_ra(0, 12);
        expect_v("uf_byp", 0, 0, 32'hCC);
        expect_v("uf_err_pre", 3, 0, 32'h0);
        cyc();
        expect_v("uf_err", 3, 0, 32'h1);
        expect_v("uf_busy", 1, 0, 32'h0);
        expect_v("uf_rd", 0, 0, 32'hCC);
        cyc();
        expect_v("uf_err_sticky", 3, 0, 32'h1);

        // Mid-run reset discards data and pending state
        cyc(); reset = 1'b0;
        expect_v("rst2_err", 3, 0, 32'h0);
        expect_v("rst2_rd", 0, 0, 32'h0);
        cyc(); reset = 1'b1; set_ra(0, 5); set_ra(1, 9);
        expect_v("rst2_r5", 0, 0, 32'h0);
        expect_v("rst2_busy9", 1, 1, 32'h0);
        expect_v("rst2_err_rel", 3, 0, 32'h0);
        iss_a = 9;
        expect_v("rst2_iss_ok", 2, 0, 32'h1);

        @(negedge clk);
        #1;
        if (eq.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d expected 0", eq.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
Parametrised general-purpose register file, the successor to the single-write, two-read MIPS RF. It adds:
- N combinational read ports.
- Two prioritised write ports (port 1 is the younger instruction).
- Optional write-to-read bypass.
- A per-register pending-write scoreboard, which drives the hazard/stall unit of the pipelined datapath.

Sits in ID (reads, issue) and WB (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NRD, 3, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value
PEND_W, 2, width of per-register pending counter (max 2**PEND_W-1 in-flight writes)
TRACE, 1, 1 = emit write trace via $display

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
ra  in  NRD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rbusy  out  NRD  port k's register still has pending writes
we0  in  1  write port 0 enable
wa0  in  ADDR_W  write port 0 address
wd0  in  DATA_W  write port 0 data
wpc0  in  32  write port 0 PC (trace only)
we1  in  1  write port 1 enable (priority)
wa1  in  ADDR_W  write port 1 address
wd1  in  DATA_W  write port 1 data
wpc1  in  32  write port 1 PC (trace only)
iss_en  in  1  issue: mark one pending write
iss_a  in  ADDR_W  issue destination register
iss_ok  out  1  issue accepted: counter[iss_a] != max, or iss_a == 0
err  out  1  sticky: write retired with zero pending count

Behaviour:
- Reset (reset==0, async): all registers 0, all pending counters 0, err 0. Hence rd = 0 and rbusy = 0 while reset is held.
- Register 0: reads always return 0; never written, never pending; issues to r0 are ignored; writes to r0 do not touch counters or err.
- Read path is combinational, zero latency. rd[k] = reg[ra_k].
- With BYPASS=1, if we1 && wa1==ra_k (nonzero), rd[k] = wd1. Otherwise, if we0 && wa0==ra_k, rd[k] = wd0.
- Write: on posedge, reg[wa0] <= wd0 if we0; reg[wa1] <= wd1 if we1. If both enabled to the same nonzero address, wd1 wins.
- Scoreboard, per register r at posedge: next = cnt + inc - dec.
  - inc = iss_en && iss_a==r && iss_ok.
  - dec = (we0 && wa0==r) + (we1 && wa1==r), so 0..2.
- Scoreboard boundaries:
  - Issue and write to the same register in the same cycle: net change applied, e.g. cnt 1 → 1.
  - Both write ports to the same register: dec = 2.
  - If cnt + inc < dec: clamp to 0 and set err (cleared only by reset).
  - iss_en while at max: iss_ok = 0, counter unchanged, no error.
- rbusy[k] = (cnt[ra_k] - dec_this_cycle(ra_k)) != 0, clamped at 0. This excludes a same-cycle issue, so a register being written back this cycle is not reported busy.
- TRACE=1: each posedge with an enabled write prints "@%h: $%d <= %h" (wpc, wa, wd).
  - Port 0 prints first, then port 1.
  - The port-0 line is suppressed when overridden by port 1 at the same address.
  - Writes to r0 still print (matches golden trace).
- Async reset asserted mid-operation discards all in-flight pending state. No write completes in a cycle where reset is low at the edge.

Test Plan:
- Reset: hold reset=0 with we0=1, wa0=3, wd0=32'hDEAD over an edge → reg3 stays 0, rd=0, err=0. Release and write again → rd(ra=3) = 32'hDEAD on the next cycle.
- Dual write collision: we0=we1=1, wa0=wa1=7, wd0=32'h1111, wd1=32'h2222 → reg7 = 32'h2222. Trace prints only the 32'h2222 line. With BYPASS=1, rd(ra=7) shows 32'h2222 in the same cycle.
- Zero register: we1=1, wa1=0, wd1=32'hFFFF_FFFF; iss_a=0 → rd(ra=0)=0, rbusy=0, iss_ok=1, counters unchanged.
- Scoreboard saturation (PEND_W=2): 3 issues to r5 → 4th issue gives iss_ok=0. Then three writes to r5 → rbusy 1,1,0 as each write is seen.
- Simultaneous issue+write: cnt[r9]=1, iss_a=9 and we0 to r9 in the same cycle → cnt stays 1 and rbusy(r9)=0 that cycle. Next cycle rbusy=1.
- Underflow: write r12 with cnt=0 → err=1 and stays 1 until reset; cnt[r12]=0.
